// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression round sequencer: loads a..h from the chaining value, runs 64
// rounds consuming W[t] over a valid/ready handshake, then adds the chaining value back.
module sha256_round_ctrl #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [8*DATA_WIDTH-1:0] hash_in,
   input  logic [DATA_WIDTH-1:0]   w_in,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [5:0]              round_idx,
   output logic                    busy,
   output logic                    done,
   output logic [8*DATA_WIDTH-1:0] hash_out
);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   state_t       state_reg;
   logic [5:0]   t_reg;
   logic [31:0]  wv_reg [8];
   logic [31:0]  chain_reg [8];
   logic [31:0]  hash_words [8];
   logic [255:0] sum_flat;
   logic [255:0] hash_out_reg;
   logic         done_reg;
   logic [31:0]  ch, maj, t1, t2;

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   // Word 0 (H0 / a) lives in the most significant 32 bits of the flat buses.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_words
         assign hash_words[gi]               = hash_in[255-32*gi -: 32];
         assign sum_flat[255-32*gi -: 32]    = chain_reg[gi] + wv_reg[gi];
      end
   endgenerate

   always_comb begin
      ch  = (wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]);
      maj = (wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]);
      t1  = wv_reg[7] + big_sigma1(wv_reg[4]) + ch + K_TAB[t_reg] + w_in;
      t2  = big_sigma0(wv_reg[0]) + maj;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         t_reg        <= '0;
         done_reg     <= 1'b0;
         hash_out_reg <= '0;
         for (int i = 0; i < 8; i++) begin
            wv_reg[i]    <= '0;
            chain_reg[i] <= '0;
         end
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  wv_reg    <= hash_words;
                  chain_reg <= hash_words;
                  t_reg     <= '0;
                  state_reg <= ROUND;
               end
            end
            ROUND: begin
               if (w_valid) begin
                  wv_reg[7] <= wv_reg[6];
                  wv_reg[6] <= wv_reg[5];
                  wv_reg[5] <= wv_reg[4];
                  wv_reg[4] <= wv_reg[3] + t1;
                  wv_reg[3] <= wv_reg[2];
                  wv_reg[2] <= wv_reg[1];
                  wv_reg[1] <= wv_reg[0];
                  wv_reg[0] <= t1 + t2;
                  // t saturates at 63; the last round hands over to FINAL instead.
                  if (t_reg == 6'd63) begin
                     state_reg <= FINAL;
                  end else begin
                     t_reg <= t_reg + 6'd1;
                  end
               end
            end
            FINAL: begin
               hash_out_reg <= sum_flat;
               done_reg     <= 1'b1;
               t_reg        <= '0;
               state_reg    <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign w_ready   = (state_reg == ROUND);
   assign round_idx = (state_reg == ROUND) ? t_reg : 6'd0;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign hash_out  = hash_out_reg;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: known-answer digests plus a plain
// SHA-256 compression model for randomized blocks, stalls and control corner cases.
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [255:0] hash_in = '0;
   logic [31:0]  w_in = '0;
   logic         w_valid = 1'b0;
   logic         w_ready;
   logic [5:0]   round_idx;
   logic         busy;
   logic         done;
   logic [255:0] hash_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0]  sched [64];
   logic [255:0] last_digest = '0;

   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [511:0] MB1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
   localparam logic [511:0] MB2 = {480'h0, 32'h000001c0};
   localparam logic [255:0] TWO_DIGEST = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   sha256_round_ctrl #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .hash_in   (hash_in),
      .w_in      (w_in),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .round_idx (round_idx),
      .busy      (busy),
      .done      (done),
      .hash_out  (hash_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Standard message-schedule expansion of one 512-bit block.
   task automatic build_schedule(input logic [511:0] blk);
      logic [31:0] s0, s1;
      for (int j = 0; j < 16; j++) sched[j] = blk[511-32*j -: 32];
      for (int j = 16; j < 64; j++) begin
         s0 = rotr(sched[j-15], 7) ^ rotr(sched[j-15], 18) ^ (sched[j-15] >> 3);
         s1 = rotr(sched[j-2], 17) ^ rotr(sched[j-2], 19) ^ (sched[j-2] >> 10);
         sched[j] = sched[j-16] + s0 + sched[j-7] + s1;
      end
   endtask

   // Full compression of the current schedule on chaining value h.
   function automatic logic [255:0] model_compress(input logic [255:0] h);
      logic [31:0]  v [8];
      logic [31:0]  x1, x2;
      logic [255:0] r;
      for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + sched[t];
         x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
              + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + x1;
         v[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
      return r;
   endfunction

   // Drives one block from a negedge: start now, feed W[t] with random stalls,
   // return at the negedge where done is seen (or when the budget expires).
   task automatic run_block(input logic [255:0] h, input int stall_pct, input int busy_start_idx,
                            output int latency, output int stalls, output int idx_errs,
                            output bit busy_first, output bit timed_out);
      int idx;
      bit v, r;
      idx = 0; stalls = 0; idx_errs = 0; latency = 0;
      start = 1'b1; hash_in = h; w_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      hash_in = ~h;
      busy_first = (busy === 1'b1);
      while (done !== 1'b1 && latency < 2000) begin
         r = (w_ready === 1'b1);
         if (r) begin
            if (round_idx !== idx[5:0]) idx_errs++;
            v = ($urandom_range(99) >= stall_pct);
            if (!v) stalls++;
            w_valid = v;
            w_in = sched[idx % 64];
            if (idx == busy_start_idx) begin
               start = 1'b1;
               hash_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
         end else begin
            v = 1'b0;
            w_valid = $urandom_range(1);
            w_in = $urandom;
         end
         @(negedge clk);
         start = 1'b0;
         latency++;
         if (r && v) idx++;
      end
      w_valid = 1'b0;
      timed_out = (done !== 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (w_ready !== 1'b0) begin n_errors++; $display("FAIL reset_w_ready: got %b want 0", w_ready); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (round_idx !== 6'd0) begin n_errors++; $display("FAIL reset_round_idx: got %0d want 0", round_idx); end
      n_checks++; if (hash_out !== 256'h0) begin n_errors++; $display("FAIL reset_hash_out: got %h want 0", hash_out); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL reset_release: busy=%b done=%b want 0 0", busy, done); end
      last_digest = '0;
      $display("reset: outputs idle");
   endtask

   task automatic test_abc();
      int lat, st, ie;
      bit bf, to;
      logic [255:0] exp;
      build_schedule(ABC_BLOCK);
      exp = model_compress(IV);
      @(negedge clk);
      run_block(IV, 0, -1, lat, st, ie, bf, to);
      $display("abc: latency=%0d stalls=%0d digest=%h", lat, st, hash_out);
      n_checks++; if (to) begin n_errors++; $display("FAIL abc_timeout: no done within %0d cycles", lat); end
      n_checks++; if (hash_out !== exp) begin n_errors++; $display("FAIL abc_model: got %h want %h", hash_out, exp); end
      n_checks++; if (hash_out !== ABC_DIGEST) begin n_errors++; $display("FAIL abc_known: got %h want %h", hash_out, ABC_DIGEST); end
      n_checks++; if (lat != 65) begin n_errors++; $display("FAIL abc_latency: got %0d want 65", lat); end
      n_checks++; if (ie != 0) begin n_errors++; $display("FAIL abc_round_idx: %0d bad cycles want 0", ie); end
      n_checks++; if (!bf) begin n_errors++; $display("FAIL abc_busy_after_start: got 0 want 1"); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abc_busy_in_done: got %b want 0", busy); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL abc_done_width: got %b want 0", done); end
      n_checks++; if (hash_out !== exp) begin n_errors++; $display("FAIL abc_hold: got %h want %h", hash_out, exp); end
      last_digest = exp;
   endtask

   task automatic test_stall();
      int lat, st, ie;
      bit bf, to;
      build_schedule(ABC_BLOCK);
      @(negedge clk);
      run_block(IV, 50, -1, lat, st, ie, bf, to);
      $display("stall: latency=%0d stalls=%0d digest=%h", lat, st, hash_out);
      n_checks++; if (to) begin n_errors++; $display("FAIL stall_timeout: no done within %0d cycles", lat); end
      n_checks++; if (hash_out !== ABC_DIGEST) begin n_errors++; $display("FAIL stall_digest: got %h want %h", hash_out, ABC_DIGEST); end
      n_checks++; if (lat != 65 + st) begin n_errors++; $display("FAIL stall_latency: got %0d want %0d", lat, 65 + st); end
      n_checks++; if (ie != 0) begin n_errors++; $display("FAIL stall_round_idx: %0d bad cycles want 0", ie); end
      last_digest = ABC_DIGEST;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         w_valid = 1'b1;
         w_in = $urandom;
         @(negedge clk);
         n_checks++;
         if (w_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 6'd0 || hash_out !== last_digest) begin
            n_errors++;
            $display("FAIL idle_cycle%0d: ready=%b busy=%b done=%b idx=%0d hash=%h want 0 0 0 0 %h",
                     i, w_ready, busy, done, round_idx, hash_out, last_digest);
         end
      end
      w_valid = 1'b0;
      $display("idle: 20 cycles with w_valid=1");
   endtask

   task automatic test_start_busy();
      int lat, st, ie, extra;
      bit bf, to;
      build_schedule(ABC_BLOCK);
      @(negedge clk);
      run_block(IV, 20, 10, lat, st, ie, bf, to);
      $display("start_busy: latency=%0d stalls=%0d digest=%h", lat, st, hash_out);
      n_checks++; if (to) begin n_errors++; $display("FAIL busy_start_timeout: no done within %0d cycles", lat); end
      n_checks++; if (hash_out !== ABC_DIGEST) begin n_errors++; $display("FAIL busy_start_digest: got %h want %h", hash_out, ABC_DIGEST); end
      n_checks++; if (lat != 65 + st) begin n_errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, 65 + st); end
      extra = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      n_checks++; if (extra != 0) begin n_errors++; $display("FAIL busy_start_done_count: %0d extra pulses want 0", extra); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_start_relaunch: busy=%b want 0", busy); end
      last_digest = ABC_DIGEST;
   endtask

   task automatic test_reset_mid();
      int idx, pulses;
      bit reached;
      build_schedule(ABC_BLOCK);
      @(negedge clk);
      start = 1'b1; hash_in = IV;
      @(negedge clk);
      start = 1'b0;
      idx = 0; reached = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (w_ready === 1'b1 && round_idx === 6'd30) begin
            reached = 1'b1;
            break;
         end
         w_valid = 1'b1;
         w_in = sched[idx % 64];
         @(negedge clk);
         idx++;
      end
      w_valid = 1'b0;
      n_checks++; if (!reached) begin n_errors++; $display("FAIL reset_mid_reach: round 30 not reached, idx=%0d", round_idx); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (w_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_idx !== 6'd0 || hash_out !== 256'h0) begin
         n_errors++;
         $display("FAIL reset_mid_outputs: ready=%b busy=%b done=%b idx=%0d hash=%h want all 0",
                  w_ready, busy, done, round_idx, hash_out);
      end
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) pulses++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) pulses++;
      end
      n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL reset_mid_done: %0d pulses want 0", pulses); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
      last_digest = '0;
      $display("reset_mid: aborted at round 30");
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, st, ie, gap;
      bit bf, to1, to2;
      time t1;
      logic [255:0] exp1, exp2;
      build_schedule(MB1);
      exp1 = model_compress(IV);
      @(negedge clk);
      run_block(IV, 0, -1, lat1, st, ie, bf, to1);
      t1 = $time;
      $display("b2b block1: latency=%0d digest=%h", lat1, hash_out);
      n_checks++; if (to1) begin n_errors++; $display("FAIL b2b_timeout1: no done within %0d cycles", lat1); end
      n_checks++; if (hash_out !== exp1) begin n_errors++; $display("FAIL b2b_block1: got %h want %h", hash_out, exp1); end
      build_schedule(MB2);
      exp2 = model_compress(exp1);
      run_block(hash_out, 0, -1, lat2, st, ie, bf, to2);
      gap = int'(($time - t1) / 10);
      $display("b2b block2: latency=%0d gap=%0d digest=%h", lat2, gap, hash_out);
      n_checks++; if (to2) begin n_errors++; $display("FAIL b2b_timeout2: no done within %0d cycles", lat2); end
      n_checks++; if (gap != 66) begin n_errors++; $display("FAIL b2b_period: got %0d want 66", gap); end
      n_checks++; if (hash_out !== exp2) begin n_errors++; $display("FAIL b2b_model: got %h want %h", hash_out, exp2); end
      n_checks++; if (hash_out !== TWO_DIGEST) begin n_errors++; $display("FAIL b2b_known: got %h want %h", hash_out, TWO_DIGEST); end
      last_digest = exp2;
   endtask

   task automatic test_random();
      int lat, st, ie;
      bit bf, to;
      logic [511:0] blk;
      logic [255:0] h, exp;
      for (int n = 0; n < 3; n++) begin
         for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = $urandom;
         for (int j = 0; j < 8; j++) h[255-32*j -: 32] = $urandom;
         build_schedule(blk);
         exp = model_compress(h);
         @(negedge clk);
         run_block(h, 30, -1, lat, st, ie, bf, to);
         $display("random%0d: latency=%0d stalls=%0d digest=%h", n, lat, st, hash_out);
         n_checks++; if (to) begin n_errors++; $display("FAIL random%0d_timeout: no done within %0d cycles", n, lat); end
         n_checks++; if (hash_out !== exp) begin n_errors++; $display("FAIL random%0d_digest: got %h want %h", n, hash_out, exp); end
         n_checks++; if (lat != 65 + st) begin n_errors++; $display("FAIL random%0d_latency: got %0d want %0d", n, lat, 65 + st); end
         n_checks++; if (ie != 0) begin n_errors++; $display("FAIL random%0d_round_idx: %0d bad cycles want 0", n, ie); end
         last_digest = exp;
      end
   endtask

   initial begin
      #3;
      test_reset();
      test_idle();
      test_abc();
      test_stall();
      test_idle();
      test_start_busy();
      test_reset_mid();
      test_abc();
      test_back_to_back();
      test_idle();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencer for the SHA-256 compression loop. It loads the eight working variables from an incoming chaining value and runs 64 rounds. Each round consumes one message-schedule word W[t] through a valid/ready handshake and uses the team's maj, ch and Σ/σ functions with an internal K[0..63] constant table. At the end it adds the chaining value back in and presents the 256-bit intermediate hash. It sits between the message scheduler (which supplies W[t]) and the top-level block/padding controller (which issues start and collects the digest).

## Interface
- DATA_WIDTH, 32, word width; only 32 is supported.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin compressing one block; sampled only in IDLE.
- hash_in  in  256  chaining value H0..H7; H0 = [255:224], H7 = [31:0]; sampled on the accepted start.
- w_in  in  32  message-schedule word W[round_idx].
- w_valid  in  1  w_in is valid.
- w_ready  out  1  controller will consume w_in this cycle.
- round_idx  out  6  index t of the word currently requested.
- busy  out  1  a block is in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse; hash_out is valid.
- hash_out  out  256  H0'..H7', same word ordering as hash_in.

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE:
  - start=1 loads a..h from hash_in words 0..7.
  - Copies hash_in into a 256-bit chaining register.
  - Sets t=0 and moves to ROUND.
- ROUND:
  - w_ready=1 and round_idx=t.
  - On w_valid & w_ready:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + w_in
    - T2 = Σ0(a) + Maj(a,b,c)
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
    - t←t+1
  - Accepting t=63 moves to FINAL; t never wraps.
  - w_valid=0 holds all state (stall of any length).
- Round functions:
  - Σ0 = ROTR2^ROTR13^ROTR22
  - Σ1 = ROTR6^ROTR11^ROTR25
  - Ch = (e&f)^(~e&g)
  - Maj = (a&b)^(a&c)^(b&c)
- FINAL:
  - hash_out word i ← chain[i] + working var i (a..h), each a 32-bit add mod 2^32 with carries discarded.
  - done←1, state←IDLE.
- hash_out holds its value until the next FINAL. A new start does not clear it.
- start while busy is ignored. hash_in changes while busy have no effect.
- w_ready=0 in IDLE and FINAL. w_valid outside ROUND is ignored.
- round_idx = 0 outside ROUND.
- K table: the 64 standard FIPS 180-4 constants, K[0]=428a2f98 … K[63]=c67178f2.

## Timing
- Reset (async assert, sync release) gives:
  - state IDLE, t=0, a..h = 0, chaining register = 0
  - hash_out = 0, done = 0, busy = 0, w_ready = 0, round_idx = 0
- Reset mid-block aborts immediately. No done pulse is produced and hash_out returns to 0.
- Start accepted on edge E0. busy=1 from the cycle after E0.
- With w_valid held high, rounds are consumed on edges E1..E64 and FINAL executes on E65.
- In the cycle after E65: done=1, busy=0, hash_out valid.
- Latency from start edge to done is 65 cycles plus the number of stalled ROUND cycles.
- done is high for exactly one cycle.
- start may be asserted during the done cycle; it is accepted on that edge, giving back-to-back blocks with a 66-cycle period.
- All outputs are registered or decoded from state only. There is no combinational path from w_valid, w_in or start to any output.

## Test plan
- Single-block "abc":
  - Stimulus: hash_in = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; W0=61626380, W1..W14=0, W15=00000018, W16..63 from the model; w_valid always 1.
  - Required: done 65 cycles after start; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Stall handling: same as "abc" but w_valid driven by a random ~50% pattern.
  - Required: identical digest; done latency = 65 + number of cycles with w_valid=0 in ROUND.
  - Required: round_idx advances only on handshake edges.
- Reset mid-block: assert rst_n=0 while round_idx=30.
  - Required: all outputs 0 in the same cycle, with no done pulse.
  - Required: after release, a fresh "abc" run gives the correct digest.
- Start while busy: pulse start with different hash_in at round_idx=10.
  - Required: ignored; the "abc" digest is unchanged; exactly one done pulse.
- Back-to-back two-block message: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with block 2 started in the done cycle of block 1 using hash_out as hash_in.
  - Required: second done exactly 66 cycles after the first.
  - Required: hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Idle behaviour: w_valid=1 with random w_in while IDLE for 20 cycles.
  - Required: w_ready=0, busy=0, done=0, hash_out unchanged.
